coord_packet_decoder: RTL and testbench

COORD_PACKET_DECODER -- requirements
Module: coord_packet_decoder

---
 rtl/coord_packet_decoder.sv | 154 +++++++++++++++
 tb/tb_coord_packet_decoder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/coord_packet_decoder.sv
// ---------------------------------------------------------------------------
// coord_packet_decoder
//
// Decodes 5-byte center-of-mass coordinate packets from a UART byte stream:
//   HEADER, XHI = {7'b0, x[8]}, XLO = x[7:0], Y = y[7:0], CHK = XHI^XLO^Y
// A packet is accepted only when the checksum matches and the coordinates
// are inside the legal frame. All other packets are discarded and counted.
// Any packet that stalls between bytes for too long is discarded as well.
//
// Ports
//   clk_in         sole clock, rising edge
//   rst_in         synchronous, active-high reset
//   byte_in        received UART byte
//   byte_valid_in  one-cycle strobe qualifying byte_in
//   x_out          last good x (9 bits)
//   y_out          last good y (8 bits)
//   valid_out      one-cycle pulse when x_out/y_out update
//   pkt_err_out    one-cycle pulse when a packet is discarded
//   err_count_out  saturating count of discarded packets
// ---------------------------------------------------------------------------
module coord_packet_decoder #(
    parameter logic [7:0] HEADER         = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 40000,
    parameter int         X_MAX          = 319,
    parameter int         Y_MAX          = 179
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] byte_in,
    input  logic       byte_valid_in,
    output logic [8:0] x_out,
    output logic [7:0] y_out,
    output logic       valid_out,
    output logic       pkt_err_out,
    output logic [7:0] err_count_out
);

    localparam int GAP_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        HUNT,
        GET_XHI,
        GET_XLO,
        GET_Y,
        GET_CHK
    } state_t;

    state_t             state_q, state_n;
    logic [GAP_W-1:0]   gap_q, gap_n;
    logic               xhi_q;
    logic [7:0]         xlo_q;
    logic [7:0]         y_q;

    logic               cap_xhi, cap_xlo, cap_y;
    logic               good_pkt, discard;
    logic [7:0]         chk_expect;
    logic               in_range;

    // Only bit 0 of XHI can be nonzero once the byte is accepted.
    assign chk_expect = {7'b0, xhi_q} ^ xlo_q ^ y_q;
    assign in_range   = (32'({xhi_q, xlo_q}) <= X_MAX) && (32'(y_q) <= Y_MAX);

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_n  = state_q;
        gap_n    = gap_q;
        cap_xhi  = 1'b0;
        cap_xlo  = 1'b0;
        cap_y    = 1'b0;
        good_pkt = 1'b0;
        discard  = 1'b0;

        if (byte_valid_in) begin
            // A byte that lands exactly on the last allowed gap cycle is
            // taken normally; the timeout branch below is never reached.
            gap_n = '0;
            unique case (state_q)
                HUNT: begin
                    if (byte_in == HEADER) state_n = GET_XHI;
                end
                GET_XHI: begin
                    if (byte_in[7:1] != 7'd0) begin
                        discard = 1'b1;
                        state_n = HUNT;
                    end else begin
                        cap_xhi = 1'b1;
                        state_n = GET_XLO;
                    end
                end
                // No resync on HEADER inside a packet: payload bytes may
                // legitimately equal the header value.
                GET_XLO: begin
                    cap_xlo = 1'b1;
                    state_n = GET_Y;
                end
                GET_Y: begin
                    cap_y   = 1'b1;
                    state_n = GET_CHK;
                end
                GET_CHK: begin
                    state_n = HUNT;
                    if ((byte_in == chk_expect) && in_range) good_pkt = 1'b1;
                    else                                     discard  = 1'b1;
                end
                default: state_n = HUNT;
            endcase
        end else if (state_q != HUNT) begin
            if (gap_q == GAP_LAST) begin
                discard = 1'b1;
                state_n = HUNT;
                gap_n   = '0;
            end else begin
                gap_n = gap_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= HUNT;
            gap_q         <= '0;
            xhi_q         <= 1'b0;
            xlo_q         <= 8'd0;
            y_q           <= 8'd0;
            x_out         <= 9'd0;
            y_out         <= 8'd0;
            valid_out     <= 1'b0;
            pkt_err_out   <= 1'b0;
            err_count_out <= 8'd0;
        end else begin
            state_q     <= state_n;
            gap_q       <= gap_n;
            valid_out   <= good_pkt;
            pkt_err_out <= discard;

            if (cap_xhi) xhi_q <= byte_in[0];
            if (cap_xlo) xlo_q <= byte_in;
            if (cap_y)   y_q   <= byte_in;

            if (good_pkt) begin
                x_out <= {xhi_q, xlo_q};
                y_out <= y_q;
            end

            if (discard && (err_count_out != 8'hFF))
                err_count_out <= err_count_out + 8'd1;
        end
    end

endmodule

// File: tb/tb_coord_packet_decoder.sv
// ---------------------------------------------------------------------------
// tb_coord_packet_decoder
//
// Directed bench for coord_packet_decoder with hand-computed expectations.
// A short TIMEOUT_CYCLES keeps the gap tests quick. Inputs change 1 time unit
// after a rising edge; outputs are sampled at the same point, so a registered
// result from the edge that consumed a byte is visible right after drive().
// ---------------------------------------------------------------------------
module tb_coord_packet_decoder;

    localparam int T = 16;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [7:0] byte_in;
    logic       byte_valid_in;
    logic [8:0] x_out;
    logic [7:0] y_out;
    logic       valid_out;
    logic       pkt_err_out;
    logic [7:0] err_count_out;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    coord_packet_decoder #(
        .HEADER         (8'hA5),
        .TIMEOUT_CYCLES (T),
        .X_MAX          (319),
        .Y_MAX          (179)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .byte_in       (byte_in),
        .byte_valid_in (byte_valid_in),
        .x_out         (x_out),
        .y_out         (y_out),
        .valid_out     (valid_out),
        .pkt_err_out   (pkt_err_out),
        .err_count_out (err_count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Strobe one byte for exactly one edge; consecutive calls are back-to-back.
    task automatic drive(input logic [7:0] b);
        byte_in       = b;
        byte_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        byte_valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // valid_out and pkt_err_out must never coincide.
    always @(negedge clk_in) begin
        if (!rst_in) chk("exclusive", {31'd0, valid_out & pkt_err_out}, 32'd0);
    end

    initial begin
        rst_in        = 1'b1;
        byte_in       = 8'h00;
        byte_valid_in = 1'b0;
        idle(3);

        // Reset state
        chk("rst_x",     x_out,         0);
        chk("rst_y",     y_out,         0);
        chk("rst_valid", valid_out,     0);
        chk("rst_err",   pkt_err_out,   0);
        chk("rst_cnt",   err_count_out, 0);
        rst_in = 1'b0;
        idle(1);

        // Largest legal coordinates, back-to-back bytes
        drive(8'hA5); drive(8'h01); drive(8'h3F); drive(8'hB3); drive(8'h8D);
        chk("max_valid", valid_out,     1);
        chk("max_x",     x_out,         319);
        chk("max_y",     y_out,         179);
        chk("max_cnt",   err_count_out, 0);
        idle(1);
        chk("max_pulse_end", valid_out, 0);

        // Leading junk dropped silently; HEADER-valued payload bytes accepted
        drive(8'h12);
        chk("junk_noerr", pkt_err_out, 0);
        drive(8'hA5); drive(8'h00); drive(8'hA5); drive(8'hA5); drive(8'h00);
        chk("hdr_valid", valid_out,   1);
        chk("hdr_x",     x_out,       165);
        chk("hdr_y",     y_out,       165);
        chk("hdr_noerr", pkt_err_out, 0);
        idle(1);

        // Bad checksum
        drive(8'hA5); drive(8'h00); drive(8'h10); drive(8'h20); drive(8'h31);
        exp_cnt++;
        chk("chk_err",   pkt_err_out,   1);
        chk("chk_noval", valid_out,     0);
        chk("chk_cnt",   err_count_out, exp_cnt);
        chk("chk_x",     x_out,         165);
        chk("chk_y",     y_out,         165);
        idle(1);
        chk("chk_pulse_end", pkt_err_out, 0);

        // x one past the limit, then a good packet
        drive(8'hA5); drive(8'h01); drive(8'h40); drive(8'h00); drive(8'h41);
        exp_cnt++;
        chk("xrng_err", pkt_err_out,   1);
        chk("xrng_cnt", err_count_out, exp_cnt);
        chk("xrng_x",   x_out,         165);
        drive(8'hA5); drive(8'h00); drive(8'h05); drive(8'h06); drive(8'h03);
        chk("after_valid", valid_out, 1);
        chk("after_x",     x_out,     5);
        chk("after_y",     y_out,     6);

        // y one past the limit (0xB4 = 180)
        drive(8'hA5); drive(8'h00); drive(8'h00); drive(8'hB4); drive(8'hB4);
        exp_cnt++;
        chk("yrng_err", pkt_err_out,   1);
        chk("yrng_cnt", err_count_out, exp_cnt);
        chk("yrng_y",   y_out,         6);

        // Bad XHI byte discards immediately
        drive(8'hA5); drive(8'h02);
        exp_cnt++;
        chk("xhi_err", pkt_err_out,   1);
        chk("xhi_cnt", err_count_out, exp_cnt);
        idle(1);

        // Gap of T idle cycles times out; T-1 does not yet
        drive(8'hA5); drive(8'h00);
        idle(T - 1);
        chk("to_before", pkt_err_out, 0);
        idle(1);
        exp_cnt++;
        chk("to_err", pkt_err_out,   1);
        chk("to_cnt", err_count_out, exp_cnt);
        idle(1);
        chk("to_pulse_end", pkt_err_out, 0);
        drive(8'hA5); drive(8'h00); drive(8'h07); drive(8'h08); drive(8'h0F);
        chk("to_next_valid", valid_out, 1);
        chk("to_next_x",     x_out,     7);
        chk("to_next_y",     y_out,     8);
        idle(1);

        // Byte landing on the last allowed gap cycle is processed normally
        drive(8'hA5); drive(8'h00);
        idle(T - 1);
        drive(8'h09);
        chk("edge_noerr", pkt_err_out, 0);
        drive(8'h0A); drive(8'h03);
        chk("edge_valid", valid_out,     1);
        chk("edge_x",     x_out,         9);
        chk("edge_y",     y_out,         10);
        chk("edge_cnt",   err_count_out, exp_cnt);
        idle(1);

        // Saturation of the discard counter
        for (int i = 0; i < 260; i++) begin
            drive(8'hA5); drive(8'h00); drive(8'h10); drive(8'h20); drive(8'h31);
            if (exp_cnt < 255) exp_cnt++;
        end
        chk("sat_err", pkt_err_out,   1);
        chk("sat_cnt", err_count_out, 255);
        chk("sat_model", err_count_out, exp_cnt);
        idle(1);

        // Reset mid-packet abandons it silently
        drive(8'hA5); drive(8'h00); drive(8'h10);
        rst_in = 1'b1;
        idle(1);
        chk("mrst_x",     x_out,         0);
        chk("mrst_y",     y_out,         0);
        chk("mrst_valid", valid_out,     0);
        chk("mrst_err",   pkt_err_out,   0);
        chk("mrst_cnt",   err_count_out, 0);
        idle(1);
        rst_in = 1'b0;
        idle(T + 2);
        chk("post_rst_err", pkt_err_out,   0);
        chk("post_rst_cnt", err_count_out, 0);

        // First bytes after reset are hunted, not taken as payload
        drive(8'h00); drive(8'h05); drive(8'h06); drive(8'h03);
        chk("hunt_noval", valid_out,   0);
        chk("hunt_noerr", pkt_err_out, 0);
        drive(8'hA5); drive(8'h00); drive(8'h05); drive(8'h06); drive(8'h03);
        chk("hunt_valid", valid_out, 1);
        chk("hunt_x",     x_out,     5);
        chk("hunt_y",     y_out,     6);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
